// File: rtl/irrigation_pkg.sv
// Shared state encoding and default phase lengths for the irrigation sequencer.
package irrigation_pkg;
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FILL     = 2'd1;
   localparam logic [1:0] ST_SPRINKLE = 2'd2;
   localparam logic [1:0] ST_DRIP     = 2'd3;

   localparam int DEF_FILL_TICKS     = 8;
   localparam int DEF_SPRINKLE_TICKS = 4;
   localparam int DEF_DRIP_TICKS     = 6;
   localparam int DEF_CNT_W          = 4;
endpackage

// File: rtl/irrigation_sequencer_edge_tick.sv
// Two-flop synchronizer plus rising-edge detector for one slow clock.
module edge_tick (
   input  logic clk_896hz,
   input  logic limpa,
   input  logic in,
   output logic tick
);
   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_896hz or posedge limpa) begin
      if (limpa) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign tick = sync2_q & ~prev_q;
endmodule

// File: rtl/irrigation_sequencer.sv
// Watering-cycle FSM: optional fill, then sprinkler, then drip,
// each phase timed by ticks from its own divided clock.
module irrigation_sequencer
   import irrigation_pkg::*;
#(
   parameter int FILL_TICKS     = DEF_FILL_TICKS,
   parameter int SPRINKLE_TICKS = DEF_SPRINKLE_TICKS,
   parameter int DRIP_TICKS     = DEF_DRIP_TICKS,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic             clk_896hz,
   input  logic             limpa,
   input  logic             start,
   input  logic             stop,
   input  logic             tank_low,
   input  logic             fill_clk,
   input  logic             sprinkler_clk,
   input  logic             drip_clk,
   output logic             valve_fill,
   output logic             valve_sprinkler,
   output logic             valve_drip,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] remaining
);
   localparam int MAXV = (1 << CNT_W) - 1;

   if (CNT_W < 1 || CNT_W > 30) begin : g_bad_w
      $error("CNT_W out of range");
   end
   if (FILL_TICKS < 1 || FILL_TICKS > MAXV) begin : g_bad_f
      $error("FILL_TICKS out of range");
   end
   if (SPRINKLE_TICKS < 1 || SPRINKLE_TICKS > MAXV) begin : g_bad_s
      $error("SPRINKLE_TICKS out of range");
   end
   if (DRIP_TICKS < 1 || DRIP_TICKS > MAXV) begin : g_bad_d
      $error("DRIP_TICKS out of range");
   end

   localparam logic [CNT_W-1:0] LD_FILL = CNT_W'(FILL_TICKS);
   localparam logic [CNT_W-1:0] LD_SPR  = CNT_W'(SPRINKLE_TICKS);
   localparam logic [CNT_W-1:0] LD_DRIP = CNT_W'(DRIP_TICKS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic fill_tick;
   logic spr_tick;
   logic drip_tick;

   edge_tick u_fill (
      .clk_896hz (clk_896hz),
      .limpa     (limpa),
      .in        (fill_clk),
      .tick      (fill_tick)
   );
   edge_tick u_spr (
      .clk_896hz (clk_896hz),
      .limpa     (limpa),
      .in        (sprinkler_clk),
      .tick      (spr_tick)
   );
   edge_tick u_drip (
      .clk_896hz (clk_896hz),
      .limpa     (limpa),
      .in        (drip_clk),
      .tick      (drip_tick)
   );

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (start && !stop) begin
            state_d = tank_low ? ST_FILL : ST_SPRINKLE;
            rem_d   = tank_low ? LD_FILL : LD_SPR;
         end
      end else if (stop) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            ST_FILL: begin
               // A full tank ends the fill early, even on a tick cycle
               if (!tank_low) begin
                  state_d = ST_SPRINKLE;
                  rem_d   = LD_SPR;
               end else if (fill_tick) begin
                  if (rem_q > ONE) begin
                     rem_d = rem_q - ONE;
                  end else begin
                     state_d = ST_SPRINKLE;
                     rem_d   = LD_SPR;
                  end
               end
            end
            ST_SPRINKLE: begin
               if (spr_tick) begin
                  if (rem_q > ONE) begin
                     rem_d = rem_q - ONE;
                  end else begin
                     state_d = ST_DRIP;
                     rem_d   = LD_DRIP;
                  end
               end
            end
            default: begin
               if (drip_tick) begin
                  if (rem_q > ONE) begin
                     rem_d = rem_q - ONE;
                  end else begin
                     state_d = ST_IDLE;
                     rem_d   = '0;
                     done_d  = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_896hz or posedge limpa) begin
      if (limpa) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign valve_fill      = (state_q == ST_FILL);
   assign valve_sprinkler = (state_q == ST_SPRINKLE);
   assign valve_drip      = (state_q == ST_DRIP);
   assign busy            = (state_q != ST_IDLE);
   assign done            = done_q;
   assign state           = state_q;
   assign remaining       = rem_q;
endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Consumer end of the divided-clock interface: takes the slow fill, sprinkler and drip clocks produced by the frequency divider and turns them into timed valve commands.
- Runs entirely in the clk_896hz domain and treats the slow clocks as asynchronous level inputs.
- Each slow-clock rising edge becomes a one-cycle tick.
- An FSM sequences one watering cycle: optional tank fill, then sprinkler, then drip.

Parameters:
- FILL_TICKS, 8, fill_clk ticks spent in FILL (legal range 1..2^CNT_W-1).
- SPRINKLE_TICKS, 4, sprinkler_clk ticks spent in SPRINKLE (legal range 1..2^CNT_W-1).
- DRIP_TICKS, 6, drip_clk ticks spent in DRIP (legal range 1..2^CNT_W-1).
- CNT_W, 4, width of the phase down-counter.

Ports:
- clk_896hz  in  1  system clock; all flops are on the rising edge.
- limpa  in  1  asynchronous, active-high reset.
- start  in  1  request a watering cycle (level, sampled each clock).
- stop  in  1  synchronous abort to IDLE.
- tank_low  in  1  tank sensor: 1 means fill required.
- fill_clk  in  1  slow clock from the divider (~0.8 Hz).
- sprinkler_clk  in  1  slow clock from the divider (7/15 Hz).
- drip_clk  in  1  slow clock from the divider (7/30 Hz).
- valve_fill  out  1  fill valve open.
- valve_sprinkler  out  1  sprinkler valve open.
- valve_drip  out  1  drip valve open.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion of DRIP.
- state  out  2  current FSM state.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- Reset (limpa=1, takes effect immediately):
  - state=IDLE, remaining=0, all valves=0, busy=0, done=0.
  - Synchronizer and edge flops are cleared.
  - Reset mid-phase closes every valve with no clock needed.
- Tick generation, per slow input:
  - Two-flop synchronizer, then a prev flop; tick = sync2 & ~prev.
  - An input rising before edge k gives tick=1 for exactly the cycle between edges k+1 and k+2.
  - The counter acts at edge k+2.
  - A level held high produces only one tick.
- FSM states: IDLE=0, FILL=1, SPRINKLE=2, DRIP=3.
- Outputs:
  - valve_* are decoded from the state register (Moore): valve_fill in FILL, valve_sprinkler in SPRINKLE, valve_drip in DRIP.
  - At most one valve is open at any time.
- IDLE:
  - start & ~stop & tank_low -> FILL, remaining<=FILL_TICKS.
  - start & ~stop & ~tank_low -> SPRINKLE, remaining<=SPRINKLE_TICKS.
- FILL:
  - On a fill tick with remaining>1, decrement remaining.
  - On a fill tick with remaining==1 -> SPRINKLE, load SPRINKLE_TICKS.
  - tank_low==0 sampled in FILL -> SPRINKLE next edge, load SPRINKLE_TICKS; this takes priority over a tick.
- SPRINKLE: same counting rule on sprinkler ticks; exhaustion -> DRIP, load DRIP_TICKS.
- DRIP:
  - Same counting rule on drip ticks.
  - Exhaustion -> IDLE, remaining<=0, done=1 for the one cycle following the transition edge (registered).
- Ticks from inputs not belonging to the current phase are ignored; nothing is banked for later phases.
- start while busy is ignored; a cycle never restarts itself.
- stop:
  - In any non-IDLE state -> IDLE next edge, remaining<=0, no done pulse.
  - stop beats a same-cycle tick and a same-cycle start.
  - stop in IDLE has no effect.
- start held high continuously re-triggers a new cycle on the edge after done.
- Counter never wraps: it is only decremented when >1, and reloaded on phase change.
- Parameters outside their legal range are an elaboration error.

Decomposition:
- Shared package irrigation_pkg:
  - state typedef/constants ST_IDLE, ST_FILL, ST_SPRINKLE, ST_DRIP (2-bit).
  - Default tick counts.
- One sub-module edge_tick (ports clk_896hz, limpa, in, tick): synchronizer plus rising-edge detector, instantiated three times.

Test Plan:
- Bench parameters FILL_TICKS=3, SPRINKLE_TICKS=2, DRIP_TICKS=2.
- Reset mid-SPRINKLE: assert limpa asynchronously between clock edges -> valve_sprinkler=0 before the next edge; state=0, remaining=0; no done pulse.
- Full cycle with tank_low=1, start pulsed:
  - state 1 with remaining 3, decrementing 3->2->1 on fill edges.
  - Third fill edge -> state 2, remaining 2.
  - Two sprinkler edges -> state 3; two drip edges -> state 0.
  - done high exactly 1 cycle; valves never overlap.
- tank_low=0 at start -> FILL skipped: state 0->2 directly, valve_fill never asserted.
- Tick latency: sprinkler_clk rises before edge k in SPRINKLE -> remaining changes at edge k+2 exactly.
  - sprinkler_clk held high 20 cycles -> one decrement only.
  - fill_clk and drip_clk edges during SPRINKLE -> remaining unchanged.
- tank_low drops during FILL with remaining=2, coincident with a fill tick -> state 2, remaining 2 (sensor priority).
- stop and drip tick in the same cycle with remaining=1 in DRIP -> state 0, done stays 0.
- start held high with stop=0 -> new cycle enters FILL/SPRINKLE on the edge after done.
